port_arbiter: RTL

Frame-granular round-robin arbiter that drains NUM_PORTS per-port ingress FIFOs into one egress stream. It sits between the ingress FIFOs and the egress MAC/forwarding stage. It drives each FIFO's read enable and holds a grant for a whole frame, so frames are never interleaved. Each FIFO word is {last, data}; the FIFO read data is registered, valid one cycle after read enable and held until the next read.

---
 rtl/switch_pkg.sv | 56 +++++
 rtl/port_arbiter_rr_picker.sv | 30 +++
 rtl/port_arbiter.sv | 135 +++++++++++++
 3 files changed

// File: rtl/switch_pkg.sv
// Shared switch types: arbiter states, counter width and FIFO word helpers.
// FIFO words are {last, data}; helpers take the payload width as an argument.
package switch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WAIT
  } arb_state_t;

  localparam int FRAME_CNT_W = 16;
  localparam int WORD_MAX_W  = 64;

  typedef logic [WORD_MAX_W:0] fifo_word_t;

  function automatic fifo_word_t pack_word(
    input logic                  last,
    input logic [WORD_MAX_W-1:0] data,
    input int                    width
  );
    fifo_word_t w;
    w = '0;
    for (int i = 0; i < WORD_MAX_W; i++) begin
      if (i < width) w[i] = data[i];
    end
    for (int i = 0; i <= WORD_MAX_W; i++) begin
      if (i == width) w[i] = last;
    end
    return w;
  endfunction

  function automatic logic word_last(
    input fifo_word_t w,
    input int         width
  );
    logic l;
    l = 1'b0;
    for (int i = 0; i <= WORD_MAX_W; i++) begin
      if (i == width) l = w[i];
    end
    return l;
  endfunction

  function automatic logic [WORD_MAX_W-1:0] word_data(
    input fifo_word_t w,
    input int         width
  );
    logic [WORD_MAX_W-1:0] d;
    d = '0;
    for (int i = 0; i < WORD_MAX_W; i++) begin
      if (i < width) d[i] = w[i];
    end
    return d;
  endfunction

endpackage

// File: rtl/port_arbiter_rr_picker.sv
// Round-robin picker: first requester after ptr, wrapping.
// Purely combinational; ptr itself has lowest priority.
module rr_picker
#(
  parameter int N  = 4,
  parameter int GW = 2
)(
  input  logic [N-1:0]  req,
  input  logic [GW-1:0] ptr,
  output logic          hit,
  output logic [GW-1:0] idx
);

  int p;

  // Scan ptr+1 .. ptr+N and keep the first requester.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    p   = 0;
    for (int i = 1; i <= N; i++) begin
      p = (int'(ptr) + i) % N;
      if (!hit && req[p]) begin
        hit = 1'b1;
        idx = GW'(p);
      end
    end
  end

endmodule

// File: rtl/port_arbiter.sv
// Frame-granular round-robin arbiter draining per-port FIFOs to one stream.
// Optional ARB_FRAME_CNT_EN adds per-port forwarded-frame counters.
module port_arbiter
  import switch_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int WIDTH     = 8,
  parameter int GNT_W     = $clog2(NUM_PORTS)
)(
  input  logic                           clk,
  input  logic                           rstn,
  input  logic [NUM_PORTS-1:0]           fifo_empty,
  output logic [NUM_PORTS-1:0]           fifo_rd_en,
  input  logic [NUM_PORTS*(WIDTH+1)-1:0] fifo_rd_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [WIDTH-1:0]               out_data,
  output logic                           out_last,
  output logic [GNT_W-1:0]               grant,
  output logic                           busy
`ifdef ARB_FRAME_CNT_EN
  ,
  output logic [NUM_PORTS*FRAME_CNT_W-1:0] frame_cnt
`endif
);

  arb_state_t            state;
  arb_state_t            next_state;
  logic [GNT_W-1:0]      ptr;
  logic                  hit;
  logic [GNT_W-1:0]      pick;
  logic [WIDTH:0]        sel_word;
  fifo_word_t            sel_ext;
  logic [WORD_MAX_W-1:0] data_ext;
  logic                  load_last;
  logic                  load;
  logic                  out_free;
  logic                  unused_hi;

  rr_picker #(
    .N  (NUM_PORTS),
    .GW (GNT_W)
  ) u_pick (
    .req (~fifo_empty),
    .ptr (ptr),
    .hit (hit),
    .idx (pick)
  );

  assign sel_word  = fifo_rd_data[int'(grant)*(WIDTH+1) +: WIDTH+1];
  assign sel_ext   = fifo_word_t'(sel_word);
  assign load_last = word_last(sel_ext, WIDTH);
  assign data_ext  = word_data(sel_ext, WIDTH);
  assign unused_hi = ^data_ext[WORD_MAX_W-1:WIDTH];
  assign out_free  = !out_valid || out_ready;
  assign busy      = (state != IDLE);

  // Next state, read strobe and output-register load.
  always_comb begin
    next_state = state;
    fifo_rd_en = '0;
    load       = 1'b0;
    unique case (state)
      IDLE: begin
        if (hit) next_state = READ;
      end
      READ: begin
        if (!fifo_empty[grant]) begin
          fifo_rd_en[grant] = 1'b1;
          next_state        = WAIT;
        end
      end
      WAIT: begin
        if (out_free) begin
          load       = 1'b1;
          next_state = load_last ? IDLE : READ;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= next_state;
  end

  // Grant capture on a hit; pointer moves to the port that finished.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      grant <= '0;
      ptr   <= GNT_W'(NUM_PORTS-1);
    end else begin
      if (state == IDLE && hit) grant <= pick;
      if (load && load_last)    ptr   <= grant;
    end
  end

  // Egress output register with valid/ready hold.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= data_ext[WIDTH-1:0];
      out_last  <= load_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef ARB_FRAME_CNT_EN
  logic [FRAME_CNT_W-1:0] cnt [NUM_PORTS];

  // Count a frame when its last word enters the output register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int p = 0; p < NUM_PORTS; p++) cnt[p] <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (load && load_last && grant == GNT_W'(p))
          cnt[p] <= cnt[p] + 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_cnt
    assign frame_cnt[g*FRAME_CNT_W +: FRAME_CNT_W] = cnt[g];
  end
`endif

endmodule
